// File: rtl/edge_pixel_reader.sv
// edge_pixel_reader: raster scan of the hysteresis frame in BRAM. Every pixel
// above EDGE_THRESHOLD has its {row, col} pushed into the Hough FIFO. One
// pixel can be held while the FIFO is full, so no edge is ever dropped.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing one BRAM read per cycle when nothing blocks it
// DRAIN | all addresses issued; flushing in-flight read and hold register
// DONE  | one-cycle done pulse, back to IDLE
module edge_pixel_reader #(
    parameter int WIDTH          = 8,
    parameter int HEIGHT         = 4,
    parameter int IMAGE_SIZE     = WIDTH * HEIGHT,
    parameter int EDGE_THRESHOLD = 0,
    parameter int X_W            = $clog2(WIDTH),
    parameter int Y_W            = $clog2(HEIGHT),
    localparam int ADDR_W        = $clog2(IMAGE_SIZE),
    localparam int CNT_W         = $clog2(IMAGE_SIZE + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    output logic               in_rd_en,
    output logic [ADDR_W-1:0]  in_rd_addr,
    input  logic [7:0]         in_rd_data,
    output logic               out_wr_en,
    output logic [Y_W+X_W-1:0] out_din,
    input  logic               out_full,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   edge_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [Y_W-1:0]     row_q;
    logic [X_W-1:0]     col_q;
    logic               inflight_q;
    logic [Y_W+X_W-1:0] tag_q;
    logic               hold_valid_q, hold_valid_d;
    logic [Y_W+X_W-1:0] hold_tag_q;
    logic               issue;
    logic               is_edge;
    logic               hold_set;
    logic               last_pix;
    logic               col_last;

    assign col_last = (col_q == X_W'(WIDTH - 1));
    assign last_pix = col_last && (row_q == Y_W'(HEIGHT - 1));
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    // Read issue, edge evaluation, FIFO write selection and next state.
    // A read is only issued with an empty hold register and a non-full FIFO,
    // so an in-flight read and a held pixel never coexist.
    always_comb begin
        state_d      = state_q;
        in_rd_en     = 1'b0;
        in_rd_addr   = '0;
        out_wr_en    = 1'b0;
        out_din      = '0;
        issue        = (state_q == SCAN) && !hold_valid_q && !out_full;
        is_edge      = inflight_q && (in_rd_data > 8'(EDGE_THRESHOLD));
        hold_set     = is_edge && out_full;
        hold_valid_d = hold_set || (hold_valid_q && out_full);

        if (issue) begin
            in_rd_en   = 1'b1;
            in_rd_addr = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
        end

        if (hold_valid_q && !out_full) begin
            out_wr_en = 1'b1;
            out_din   = hold_tag_q;
        end else if (is_edge && !out_full) begin
            out_wr_en = 1'b1;
            out_din   = tag_q;
        end

        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (issue && last_pix) state_d = DRAIN;
            // Leave as soon as nothing will be pending next cycle, which
            // puts done two cycles after the last read when unblocked.
            DRAIN:   if (!hold_valid_d) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, scan counters, in-flight tag, hold register and edge counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            inflight_q   <= 1'b0;
            tag_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_tag_q   <= '0;
            edge_count   <= '0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= issue;
            hold_valid_q <= hold_valid_d;
            if (hold_set) begin
                hold_tag_q <= tag_q;
            end
            if (state_q == IDLE && start) begin
                row_q      <= '0;
                col_q      <= '0;
                edge_count <= '0;
            end else begin
                if (issue) begin
                    tag_q <= {row_q, col_q};
                    if (col_last) begin
                        col_q <= '0;
                        row_q <= row_q + Y_W'(1);
                    end else begin
                        col_q <= col_q + X_W'(1);
                    end
                end
                if (out_wr_en) begin
                    edge_count <= edge_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
